dm_arbiter: RTL

//  Two-requester arbiter/sequencer for the 4096x8 byte-addressable data memory (32-bit big-endian word port).

---
 rtl/dm_arb_pkg.sv | 28 ++
 rtl/dm_rr_pick.sv | 30 +++
 rtl/dm_arbiter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dm_arb_pkg.sv
// ----------------------------------------------------------------------------
// dm_arb_pkg
// Shared types and constants for the data-memory arbiter.
//   state_t          : arbiter FSM states
//   PORT_CPU/PORT_IO : requester identifiers used by the picker and grant regs
//   last_legal()     : highest byte address at which a full 4-byte word fits
//   LAST_LEGAL_ADDR  : last_legal() for the default 12-bit address space
// ----------------------------------------------------------------------------
package dm_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    // A word occupies addr..addr+3, so the top three byte addresses cannot
    // start a word.
    function automatic int last_legal(input int addr_w);
        return (1 << addr_w) - 4;
    endfunction

    localparam int LAST_LEGAL_ADDR = last_legal(12);

endpackage

// File: rtl/dm_rr_pick.sv
// ----------------------------------------------------------------------------
// dm_rr_pick
// Combinational two-way round-robin picker.
//   req[1:0] in  : request vector, index = port ID (0 = CPU, 1 = IO)
//   last     in  : port ID that received the previous grant
//   gnt_vld  out : at least one request is present
//   gnt_id   out : winning port ID (0 when nothing is requested)
// A lone requester always wins; on a tie the port that was not granted last
// wins, so a waiting loser is always served next.
// ----------------------------------------------------------------------------
module dm_rr_pick
    import dm_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt_id
);

    always_comb begin
        gnt_vld = |req;
        gnt_id  = PORT_CPU;
        if (&req) begin
            gnt_id = ~last;
        end else if (req[PORT_IO]) begin
            gnt_id = PORT_IO;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// ----------------------------------------------------------------------------
// dm_arbiter
// Shares a byte-addressable data memory (32-bit big-endian word port) between
// the CPU MEM stage and the IO/DMA port. Each accepted request runs
// IDLE -> ACCESS -> RESP; a rejected request goes IDLE -> RESP without
// touching the memory.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   cpu_req/wr/addr/wdata, cpu_ack CPU request channel and completion pulse
//   io_req/wr/addr/wdata,  io_ack  IO request channel and completion pulse
//   rsp_rdata, rsp_err             response, valid while either ack is high
//   dm_cs/dm_wr/dm_rd/dm_addr/dm_din  registered memory controls and data
//   dm_dout                        memory read data (high-Z when not reading)
//   busy                           FSM is not in IDLE
//
// Build option
//   DM_ARB_ALIGN_CHK_EN : when defined, addresses with addr[1:0] != 0 are
//                         rejected in addition to out-of-range addresses.
// ----------------------------------------------------------------------------
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              io_req,
    input  logic              io_wr,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_ack,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              dm_cs,
    output logic              dm_wr,
    output logic              dm_rd,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    input  logic [DATA_W-1:0] dm_dout,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(last_legal(ADDR_W));

    function automatic logic is_rejected(input logic [ADDR_W-1:0] a);
`ifdef DM_ARB_ALIGN_CHK_EN
        return (a > LAST_ADDR) || (a[1:0] != 2'b00);
`else
        return (a > LAST_ADDR);
`endif
    endfunction

    state_t            state, state_nx;
    logic              last_grant, last_nx;
    logic              win_id, win_nx;
    logic              gnt_vld, gnt_id;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              cs_nx, wr_nx, rd_nx, err_nx, cack_nx, iack_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] din_nx, rdata_nx;

    dm_rr_pick u_pick (
        .req     ({io_req, cpu_req}),
        .last    (last_grant),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    assign sel_wr    = (gnt_id == PORT_IO) ? io_wr    : cpu_wr;
    assign sel_addr  = (gnt_id == PORT_IO) ? io_addr  : cpu_addr;
    assign sel_wdata = (gnt_id == PORT_IO) ? io_wdata : cpu_wdata;

    assign busy = (state != ST_IDLE);

    always_comb begin
        state_nx = state;
        last_nx  = last_grant;
        win_nx   = win_id;
        cs_nx    = 1'b0;
        wr_nx    = 1'b0;
        rd_nx    = 1'b0;
        addr_nx  = dm_addr;
        din_nx   = dm_din;
        rdata_nx = rsp_rdata;
        err_nx   = 1'b0;
        cack_nx  = 1'b0;
        iack_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gnt_vld) begin
                    win_nx  = gnt_id;
                    last_nx = gnt_id;
                    if (is_rejected(sel_addr)) begin
                        // Skip ACCESS entirely: answer in the next cycle.
                        state_nx = ST_RESP;
                        err_nx   = 1'b1;
                        rdata_nx = '0;
                        cack_nx  = (gnt_id == PORT_CPU);
                        iack_nx  = (gnt_id == PORT_IO);
                    end else begin
                        state_nx = ST_ACCESS;
                        cs_nx    = 1'b1;
                        wr_nx    = sel_wr;
                        rd_nx    = ~sel_wr;
                        addr_nx  = sel_addr;
                        din_nx   = sel_wdata;
                    end
                end
            end
            ST_ACCESS: begin
                // dm_dout is only driven while dm_rd is high, i.e. now.
                state_nx = ST_RESP;
                rdata_nx = dm_wr ? '0 : dm_dout;
                cack_nx  = (win_id == PORT_CPU);
                iack_nx  = (win_id == PORT_IO);
            end
            ST_RESP: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            last_grant <= PORT_IO;
            win_id     <= PORT_CPU;
            dm_cs      <= 1'b0;
            dm_wr      <= 1'b0;
            dm_rd      <= 1'b0;
            dm_addr    <= '0;
            dm_din     <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            cpu_ack    <= 1'b0;
            io_ack     <= 1'b0;
        end else begin
            state      <= state_nx;
            last_grant <= last_nx;
            win_id     <= win_nx;
            dm_cs      <= cs_nx;
            dm_wr      <= wr_nx;
            dm_rd      <= rd_nx;
            dm_addr    <= addr_nx;
            dm_din     <= din_nx;
            rsp_rdata  <= rdata_nx;
            rsp_err    <= err_nx;
            cpu_ack    <= cack_nx;
            io_ack     <= iack_nx;
        end
    end

endmodule
